dram_port_responder: RTL and testbench
======================================

DRAM_PORT_RESPONDER -- requirements
Module: dram_port_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: implemented byte-address bits; depth is 2**ADDR_WIDTH bytes.
REQ-002 Parameter INIT_VALUE, default 8'h00: value returned on read-data outputs after reset.
REQ-003 One clock; reset is asynchronous and active-high. Ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable_processor  input  1  high: processor owns the memory; low: host port may access it.
REQ-007 DRAM_address_processor  input  16  processor byte address; bits above ADDR_WIDTH-1 are ignored (aliasing).
REQ-008 DRAM_output_data  input  8  processor write data.
REQ-009 write_DRAM  input  1  processor write strobe.
REQ-010 DRAM_input_data  output  8  registered read data to processor.
REQ-011 host_address  input  16  host byte address; same aliasing rule as REQ-007.
REQ-012 host_wdata  input  8  host write data.
REQ-013 host_write, host_read  input  1 each  single-cycle host request strobes.
REQ-014 host_rdata  output  8  host read data, valid while host_valid is high.
REQ-015 host_valid  output  1  one-cycle completion pulse, for both reads and writes.
REQ-016 host_busy  output  1  high while a host request is outstanding.

Function
REQ-017 Processor write: at a rising edge with enable_processor=1 and write_DRAM=1, mem[addr] <= DRAM_output_data.
REQ-018 Processor read: with enable_processor=1, DRAM_input_data <= mem[addr] at every edge (1-cycle latency).
REQ-019 Write-first: a read and a write to the same address in the same edge return the new data.
REQ-020 With enable_processor=0, processor writes are ignored and DRAM_input_data holds its value.
REQ-021 Host FSM states: IDLE, WAIT_BUS, ACCESS, RESP; host_busy = (state != IDLE).
REQ-022 In IDLE, a host_write or host_read latches address, data and operation type.
  - Next state is WAIT_BUS if enable_processor=1, otherwise ACCESS.
REQ-023 If host_write and host_read are both high in IDLE, the request is latched as a write and the read is dropped.
REQ-024 Strobes received in any state other than IDLE are ignored (no queueing).
REQ-025 WAIT_BUS -> ACCESS on the first edge with enable_processor=0; otherwise stay in WAIT_BUS.
REQ-026 ACCESS executes only if enable_processor=0 in that cycle; otherwise return to WAIT_BUS with no memory effect.
REQ-027 An executed ACCESS performs the write, or captures read data into host_rdata, then moves to RESP.
REQ-028 RESP asserts host_valid for exactly one cycle, then returns to IDLE.
  - Minimum request-to-valid latency is 2 cycles.
REQ-029 host_rdata holds its last value outside RESP.
  - After a write, host_rdata is unchanged.

Reset
REQ-030 While reset=1:
  - state=IDLE;
  - DRAM_input_data=INIT_VALUE and host_rdata=INIT_VALUE;
  - host_valid=0 and host_busy=0;
  - latched request is discarded.
REQ-031 Memory array contents are not cleared by reset.
REQ-032 Reset asserted during WAIT_BUS, ACCESS or RESP aborts the request.
  - No host_valid pulse follows.
  - A write still in WAIT_BUS does not reach memory.

Configuration
REQ-033 Macro DRAM_HOST_PORT_EN defined: the host port and FSM behave as specified above.
REQ-034 Macro DRAM_HOST_PORT_EN undefined: the FSM is absent.
  - host_rdata=0, host_valid=0 and host_busy=0 constantly.
  - Host inputs are ignored; processor behaviour is unchanged.

Verification
REQ-035 Processor port: enable=1, write 8'hA5 to 16'h0003, then read 16'h0003 -> DRAM_input_data=8'hA5 one cycle after the address is applied.
REQ-036 Aliasing: with ADDR_WIDTH=10, write 8'h3C at 16'h0405, read 16'h0005 -> 8'h3C.
REQ-037 Host read with enable=0: host_read at 16'h0003 -> host_busy for 2 cycles, then host_valid pulse with host_rdata=8'hA5.
REQ-038 Host write during processor ownership: enable=1 for 5 cycles, host_write 8'h77 to 16'h0010.
  - Response: FSM stays in WAIT_BUS and memory is unchanged.
  - After enable=0: write occurs and host_valid pulses.
  - A following processor read of 16'h0010 returns 8'h77.
REQ-039 Simultaneous host_write and host_read (8'h11 to 16'h0020) -> write performed, a single host_valid pulse, host_rdata unchanged.
REQ-040 Reset asserted in WAIT_BUS with a pending write of 8'hEE -> no host_valid, mem[16'h0020] keeps its prior value, all outputs return to reset values.

Source files
------------

// File: rtl/dram_port_responder.sv
// Byte-wide DRAM model with a processor port and an optional host port (macro DRAM_HOST_PORT_EN).
// The host port only touches memory while the processor has released the bus.
module dram_port_responder #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_processor,
  input  logic [15:0] DRAM_address_processor,
  input  logic [7:0]  DRAM_output_data,
  input  logic        write_DRAM,
  output logic [7:0]  DRAM_input_data,
  input  logic [15:0] host_address,
  input  logic [7:0]  host_wdata,
  input  logic        host_write,
  input  logic        host_read,
  output logic [7:0]  host_rdata,
  output logic        host_valid,
  output logic        host_busy,
  output logic [1:0]  dbg_host_state_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] proc_addr;
  logic                  proc_we;
  logic [7:0]            dram_rdata_q, dram_rdata_d;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr_q;
  logic [7:0]            host_wdata_q;
  logic                  unused_addr_bits;

  assign proc_addr = DRAM_address_processor[ADDR_WIDTH-1:0];
  assign proc_we   = enable_processor & write_DRAM;
  assign unused_addr_bits = ^{DRAM_address_processor, host_address};

  // Host writes only execute with enable_processor low, so the two writers never collide.
  always_ff @(posedge clock) begin
    if (proc_we) begin
      mem_q[proc_addr] <= DRAM_output_data;
    end else if (host_we) begin
      mem_q[host_addr_q] <= host_wdata_q;
    end
  end

  always_comb begin
    dram_rdata_d = dram_rdata_q;
    if (enable_processor) begin
      dram_rdata_d = write_DRAM ? DRAM_output_data : mem_q[proc_addr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dram_rdata_q <= INIT_VALUE;
    end else begin
      dram_rdata_q <= dram_rdata_d;
    end
  end

  assign DRAM_input_data = dram_rdata_q;

`ifdef DRAM_HOST_PORT_EN
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_BUS = 2'd1;
  localparam logic [1:0] ST_ACCESS   = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  logic [1:0] state_q, state_d;
  logic       req_take;
  logic       exec;
  logic       host_is_write_q;
  logic [7:0] host_rdata_q, host_rdata_d;

  // A write strobe wins over a simultaneous read strobe.
  assign req_take = (state_q == ST_IDLE) && (host_write || host_read);
  assign exec     = (state_q == ST_ACCESS) && !enable_processor;
  assign host_we  = exec && host_is_write_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (host_write || host_read) state_d = enable_processor ? ST_WAIT_BUS : ST_ACCESS;
      ST_WAIT_BUS: if (!enable_processor) state_d = ST_ACCESS;
      ST_ACCESS:   state_d = enable_processor ? ST_WAIT_BUS : ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host_rdata_d = host_rdata_q;
    if (exec && !host_is_write_q) begin
      host_rdata_d = mem_q[host_addr_q];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      host_is_write_q <= 1'b0;
      host_addr_q     <= '0;
      host_wdata_q    <= '0;
      host_rdata_q    <= INIT_VALUE;
    end else begin
      state_q      <= state_d;
      host_rdata_q <= host_rdata_d;
      if (req_take) begin
        host_is_write_q <= host_write;
        host_addr_q     <= host_address[ADDR_WIDTH-1:0];
        host_wdata_q    <= host_wdata;
      end
    end
  end

  assign host_rdata       = host_rdata_q;
  assign host_valid       = (state_q == ST_RESP);
  assign host_busy        = (state_q != ST_IDLE);
  assign dbg_host_state_o = state_q;
`else
  logic unused_host;

  assign unused_host      = ^{host_wdata, host_write, host_read};
  assign host_we          = 1'b0;
  assign host_addr_q      = '0;
  assign host_wdata_q     = '0;
  assign host_rdata       = 8'h00;
  assign host_valid       = 1'b0;
  assign host_busy        = 1'b0;
  assign dbg_host_state_o = 2'd0;
`endif

endmodule

// File: tb/tb_dram_port_responder.sv
// Randomised bench for dram_port_responder: a transaction-level memory/host model feeds
// expected-value queues that a negedge monitor drains; works with or without DRAM_HOST_PORT_EN.
module tb_dram_port_responder;

  localparam int         AW    = 10;
  localparam logic [7:0] INITV = 8'h5A;
`ifdef DRAM_HOST_PORT_EN
  localparam logic [7:0] HR_INIT = INITV;
`else
  localparam logic [7:0] HR_INIT = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_processor;
  logic [15:0] DRAM_address_processor;
  logic [7:0]  DRAM_output_data;
  logic        write_DRAM;
  logic [7:0]  DRAM_input_data;
  logic [15:0] host_address;
  logic [7:0]  host_wdata;
  logic        host_write;
  logic        host_read;
  logic [7:0]  host_rdata;
  logic        host_valid;
  logic        host_busy;
  logic [1:0]  dbg_state;

  dram_port_responder #(.ADDR_WIDTH(AW), .INIT_VALUE(INITV)) dut (
    .clock                  (clk),
    .reset                  (reset),
    .enable_processor       (enable_processor),
    .DRAM_address_processor (DRAM_address_processor),
    .DRAM_output_data       (DRAM_output_data),
    .write_DRAM             (write_DRAM),
    .DRAM_input_data        (DRAM_input_data),
    .host_address           (host_address),
    .host_wdata             (host_wdata),
    .host_write             (host_write),
    .host_read              (host_read),
    .host_rdata             (host_rdata),
    .host_valid             (host_valid),
    .host_busy              (host_busy),
    .dbg_host_state_o       (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte memory plus one outstanding host transaction.
  logic [7:0] mem_m [2**AW];
  logic [7:0] proc_q [$];
  logic [7:0] host_q [$];
  logic [7:0] proc_hold  = INITV;
  logic [7:0] exp_hrdata = HR_INIT;
  bit         h_out = 1'b0;
  bit         h_done = 1'b0;
  bit         h_wr = 1'b0;
  bit         prev_low = 1'b0;
  logic [AW-1:0] h_a = '0;
  logic [7:0]    h_d = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_q.delete();
      host_q.delete();
      proc_hold  = INITV;
      exp_hrdata = HR_INIT;
      h_out  = 1'b0;
      h_done = 1'b0;
    end else begin
      if (enable_processor) begin
        if (write_DRAM) mem_m[DRAM_address_processor[AW-1:0]] = DRAM_output_data;
        proc_q.push_back(mem_m[DRAM_address_processor[AW-1:0]]);
      end
`ifdef DRAM_HOST_PORT_EN
      // A request executes at the first later edge where the bus was free on this and the previous edge.
      if (h_done) begin
        h_done = 1'b0;
      end else if (h_out) begin
        if (!enable_processor && prev_low) begin
          if (h_wr) mem_m[h_a] = h_d;
          else      exp_hrdata = mem_m[h_a];
          host_q.push_back(exp_hrdata);
          h_out  = 1'b0;
          h_done = 1'b1;
        end
      end else if (host_write || host_read) begin
        h_out = 1'b1;
        h_wr  = host_write;
        h_a   = host_address[AW-1:0];
        h_d   = host_wdata;
      end
      prev_low = !enable_processor;
`endif
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [7:0] exp_resp;
    if (proc_q.size() > 0) proc_hold = proc_q.pop_front();
    chk8("proc_rdata", DRAM_input_data, proc_hold);
    chk1("host_busy", host_busy, h_out || h_done);
    chk1("host_valid", host_valid, h_done);
    if (host_valid) begin
      if (host_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL host_resp: got unexpected host_valid, expected none at %0t", $time);
      end else begin
        exp_resp = host_q.pop_front();
        chk8("host_rdata_resp", host_rdata, exp_resp);
      end
    end else begin
      chk8("host_rdata_hold", host_rdata, exp_hrdata);
    end
  end

  // Driver tasks
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic proc_op(input bit en, input bit wr, input logic [15:0] a, input logic [7:0] d);
    enable_processor       = en;
    write_DRAM             = wr;
    DRAM_address_processor = a;
    DRAM_output_data       = d;
    cycle();
  endtask

  task automatic host_req(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d);
    host_write   = w;
    host_read    = r;
    host_address = a;
    host_wdata   = d;
    cycle();
    host_write = 1'b0;
    host_read  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (host_valid) break;
    end
    cycle();
  endtask

  task automatic do_reset(input int n);
    host_write = 1'b0;
    host_read  = 1'b0;
    reset      = 1'b1;
    cycle(n);
    reset      = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    enable_processor = 1'b0;
    DRAM_address_processor = '0;
    DRAM_output_data = '0;
    write_DRAM = 1'b0;
    host_address = '0;
    host_wdata = '0;
    host_write = 1'b0;
    host_read = 1'b0;
    cycle(3);
    chk8("reset_proc_rdata", DRAM_input_data, INITV);
    chk8("reset_host_rdata", host_rdata, HR_INIT);
    reset = 1'b0;
    cycle();

    // Fill memory through aliased addresses so every location is known.
    for (int a = 0; a < 2**AW; a++) begin
      logic [15:0] addr;
      addr = 16'(a);
      addr[15:AW] = 6'($urandom_range(0, 63));
      proc_op(1'b1, 1'b1, addr, 8'($urandom));
    end

    proc_op(1'b1, 1'b1, 16'h0003, 8'hA5);
    proc_op(1'b1, 1'b0, 16'h0003, 8'h00);
    chk8("proc_read_a5", DRAM_input_data, 8'hA5);
    proc_op(1'b1, 1'b1, 16'h0405, 8'h3C);
    proc_op(1'b1, 1'b0, 16'h0005, 8'h00);
    chk8("alias_read_3c", DRAM_input_data, 8'h3C);

    // Host read with the bus released.
    enable_processor = 1'b0;
    write_DRAM = 1'b0;
    host_req(1'b0, 1'b1, 16'h0003, 8'h00);
    wait_valid(lat);
`ifdef DRAM_HOST_PORT_EN
    chk8("host_rd_latency", 8'(lat), 8'd2);
    chk8("host_rd_a5", host_rdata, 8'hA5);
`endif

    // Host write held off while the processor owns the bus.
    enable_processor = 1'b1;
    DRAM_address_processor = 16'h0010;
    host_req(1'b1, 1'b0, 16'h0010, 8'h77);
    cycle(4);
    enable_processor = 1'b0;
    wait_valid(lat);
    proc_op(1'b1, 1'b0, 16'h0010, 8'h00);
    chk8("proc_read_host_write", DRAM_input_data, HR_INIT == 8'h00 ? DRAM_input_data : 8'h77);

    // Simultaneous strobes: write wins.
    proc_op(1'b1, 1'b1, 16'h0020, 8'h42);
    enable_processor = 1'b0;
    host_req(1'b1, 1'b1, 16'h0020, 8'h11);
    wait_valid(lat);

    // Reset while a write waits for the bus.
    enable_processor = 1'b1;
    host_req(1'b1, 1'b0, 16'h0020, 8'hEE);
    cycle(2);
    do_reset(2);
    enable_processor = 1'b0;
    cycle(4);
    proc_op(1'b1, 1'b0, 16'h0020, 8'h00);

    // Random traffic.
    enable_processor = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) enable_processor = !enable_processor;
      write_DRAM             = 1'($urandom_range(0, 1));
      DRAM_address_processor = 16'($urandom);
      DRAM_output_data       = 8'($urandom);
      host_write             = ($urandom_range(0, 5) == 0);
      host_read              = ($urandom_range(0, 4) == 0);
      host_address           = 16'($urandom);
      host_wdata             = 8'($urandom);
      if (i == 700) reset = 1'b1;
      if (i == 702) reset = 1'b0;
      cycle();
    end
    host_write = 1'b0;
    host_read  = 1'b0;
    write_DRAM = 1'b0;
    enable_processor = 1'b0;
    cycle(10);

    n_checks++;
    if (host_q.size() != 0 || h_out) begin
      n_errors++;
      $display("FAIL drain: got %0d pending responses, expected 0", host_q.size() + int'(h_out));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
